mc_datapath_g2: RTL and testbench

Second-generation multicycle RISC datapath with parametrised data and address widths. It executes one micro-step per accepted control word from the control FSM and talks to external memory through a request/acknowledge handshake, so memory may stall. It keeps a full NZCV status register with eight branch conditions, and optionally provides a debug memory port. It sits between the control unit and the memory/IO subsystem.

---
 rtl/mc_dp_pkg.sv | 71 +++++++
 rtl/mc_alu.sv | 47 ++++
 rtl/mc_datapath_g2.sv | 238 +++++++++++++++++++++++
 tb/tb_mc_datapath_g2.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_dp_pkg.sv
// Shared types for the multicycle datapath: control word layout, field encodings,
// PSW bit positions and the branch-condition evaluator.
package mc_dp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_Z, COND_NZ, COND_C, COND_NC, COND_N, COND_NN, COND_AL, COND_NV
    } cond_e;

    typedef enum logic {
        SRC_A_PC, SRC_A_REG
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_REG, SRC_B_ONE, SRC_B_IMM, SRC_B_ZERO
    } src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU, PC_SRC_ALUOUT, PC_SRC_JUMP, PC_SRC_REG
    } pc_src_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT, M2R_MDR, M2R_LLH, M2R_PC
    } mem_to_reg_e;

    localparam int PSW_N = 3;
    localparam int PSW_Z = 2;
    localparam int PSW_C = 1;
    localparam int PSW_V = 0;

    typedef struct packed {
        logic        ir_write;
        logic        reg_write;
        logic        reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        ll_or_lh;
        src_a_e      alu_src_a;
        src_b_e      alu_src_b;
        logic        imm_long;
        alu_op_e     alu_op;
        logic        psw_en;
        logic        pc_write;
        logic        branch;
        cond_e       cond;
        pc_src_e     pc_src;
        logic        jr_sel;
        logic        iord;
        logic        mem_rd;
        logic        mem_wr;
        logic        outr_en;
    } ctrl_t;

    function automatic logic cond_eval(input cond_e c, input logic [3:0] flags);
        logic t;
        case (c)
            COND_Z:  t = flags[PSW_Z];
            COND_NZ: t = ~flags[PSW_Z];
            COND_C:  t = flags[PSW_C];
            COND_NC: t = ~flags[PSW_C];
            COND_N:  t = flags[PSW_N];
            COND_NN: t = ~flags[PSW_N];
            COND_AL: t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Datapath ALU: add/sub with carry, logic ops and pass-B, plus NZCV flags.
// Subtraction is a + ~b + cin, so C=1 reads as "no borrow".
module mc_alu
    import mc_dp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv
);

    logic [DATA_W-1:0] bb;
    logic [DATA_W:0]   sum;
    logic              ci;
    logic              c_flag;
    logic              v_flag;

    always_comb begin
        bb     = (op == ALU_SUB || op == ALU_SBC) ? ~b : b;
        ci     = 1'b0;
        case (op)
            ALU_SUB:          ci = 1'b1;
            ALU_ADC, ALU_SBC: ci = cin;
            default:          ci = 1'b0;
        endcase
        sum    = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, ci};
        result = sum[DATA_W-1:0];
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
                c_flag = sum[DATA_W];
                v_flag = (a[DATA_W-1] == bb[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = b;
        endcase
        nzcv = {result[DATA_W-1], (result == '0), c_flag, v_flag};
    end

endmodule

// File: rtl/mc_datapath_g2.sv
// Multicycle RISC datapath: one micro-step per accepted control word, memory over req/ack.
// Build option DP_DBG_EN adds a debug memory port served from IDLE ahead of control steps.
//   state | meaning
//   IDLE  | ready for a control word (or a debug request)
//   MEM   | memory step latched, mem_req held until mem_ack commits it
//   DBG   | debug access in flight, finishes on mem_ack (DP_DBG_EN only)
module mc_datapath_g2
    import mc_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_valid,
    input  ctrl_t             ctrl,
    output logic              ctrl_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       opcode,
    output logic [DATA_W-1:0] outr,
    output logic [3:0]        psw
`ifdef DP_DBG_EN
    ,
    input  logic              dbg_en,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack
`endif
);

`ifdef DP_DBG_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_DBG} state_e;
`else
    typedef enum logic {ST_IDLE, ST_MEM} state_e;
`endif

    state_e state_q, state_d;

    logic [DATA_W-1:0] pc_q, mdr_q, a_q, b_q, aluout_q, outr_q, wdata_q;
    logic [15:0]       ir_q;
    logic [3:0]        psw_q;
    logic [DATA_W-1:0] rf [8];
    ctrl_t             step_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;

    ctrl_t             act;
    logic              accept, mem_done, commit, mem_step_acc, is_mem_step;
    logic [DATA_W-1:0] rf_a, rf_b, imm, ll, lh, llh, wb_data, pc_next;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic [3:0]        alu_flags;
    logic              cond_true;

`ifdef DP_DBG_EN
    logic              dbg_start, dbg_done, dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ctrl_ready  = 1'b0;
        accept      = 1'b0;
        mem_done    = 1'b0;
        is_mem_step = ctrl.mem_rd | ctrl.mem_wr;
`ifdef DP_DBG_EN
        dbg_start   = 1'b0;
        dbg_done    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DP_DBG_EN
                if (dbg_en) begin
                    dbg_start = 1'b1;
                    state_d   = ST_DBG;
                end else begin
                    ctrl_ready = 1'b1;
                end
`else
                ctrl_ready = 1'b1;
`endif
                if (ctrl_ready && ctrl_valid) begin
                    accept = 1'b1;
                    if (is_mem_step) state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`ifdef DP_DBG_EN
            ST_DBG: begin
                if (mem_ack) begin
                    dbg_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // While a memory step waits, the latched word drives the datapath so it commits at mem_ack.
    assign act          = (state_q == ST_MEM) ? step_q : ctrl;
    assign mem_step_acc = accept && is_mem_step;
    assign commit       = (accept && !is_mem_step) || mem_done;

    assign rf_a = rf[ir_q[7:5]];
    assign rf_b = rf[act.reg_dst ? ir_q[10:8] : ir_q[4:2]];
    assign imm  = act.imm_long ? {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]}
                               : {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign ll   = {{(DATA_W-8){1'b0}}, ir_q[7:0]};

    always_comb begin
        lh       = b_q;
        lh[15:8] = ir_q[7:0];
        llh      = act.ll_or_lh ? lh : ll;
    end

    assign alu_a = (act.alu_src_a == SRC_A_REG) ? a_q : pc_q;

    always_comb begin
        case (act.alu_src_b)
            SRC_B_REG: alu_b = b_q;
            SRC_B_ONE: alu_b = {{(DATA_W-1){1'b0}}, 1'b1};
            SRC_B_IMM: alu_b = imm;
            default:   alu_b = '0;
        endcase
    end

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (act.alu_op),
        .cin    (psw_q[PSW_C]),
        .result (alu_res),
        .nzcv   (alu_flags)
    );

    always_comb begin
        case (act.mem_to_reg)
            M2R_ALUOUT: wb_data = aluout_q;
            M2R_MDR:    wb_data = mdr_q;
            M2R_LLH:    wb_data = llh;
            default:    wb_data = pc_q;
        endcase
        case (act.pc_src)
            PC_SRC_ALU:    pc_next = alu_res;
            PC_SRC_ALUOUT: pc_next = aluout_q;
            PC_SRC_JUMP:   pc_next = {pc_q[DATA_W-1:11], ir_q[10:0]};
            default:       pc_next = act.jr_sel ? b_q : a_q;
        endcase
    end

    assign cond_true = cond_eval(act.cond, psw_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            outr_q   <= '0;
            ir_q     <= '0;
            psw_q    <= '0;
            step_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            if (commit) begin
                a_q      <= rf_a;
                b_q      <= rf_b;
                aluout_q <= alu_res;
                if (act.reg_write)                      rf[ir_q[10:8]] <= wb_data;
                if (act.pc_write || (act.branch && cond_true)) pc_q <= pc_next;
                if (act.psw_en)                         psw_q <= alu_flags;
                if (act.outr_en)                        outr_q <= alu_res;
            end
            if (mem_done) begin
                mdr_q <= mem_rdata;
                if (step_q.ir_write) ir_q <= mem_rdata[15:0];
            end
            if (mem_step_acc) begin
                step_q  <= ctrl;
                addr_q  <= ctrl.iord ? aluout_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
                wdata_q <= b_q;
                we_q    <= ctrl.mem_wr;
            end
`ifdef DP_DBG_EN
            if (dbg_start) begin
                addr_q  <= dbg_addr;
                wdata_q <= dbg_wdata;
                we_q    <= dbg_we;
            end
`endif
        end
    end

`ifdef DP_DBG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
        end else begin
            dbg_ack_q <= dbg_done;
            if (dbg_done && !we_q) dbg_rdata_q <= mem_rdata;
        end
    end

    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
`endif

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign opcode    = ir_q;
    assign outr      = outr_q;
    assign psw       = psw_q;

endmodule

// File: tb/tb_mc_datapath_g2.sv
// Directed bench for mc_datapath_g2: the bench plays memory and control unit,
// with hand-computed register, flag and handshake expectations.
module tb_mc_datapath_g2;
    import mc_dp_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_valid;
    ctrl_t         ctrl;
    logic          ctrl_ready;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, outr;
    logic [15:0]   opcode;
    logic [3:0]    psw;
`ifdef DP_DBG_EN
    logic          dbg_en, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
`endif

    int checks   = 0;
    int failures = 0;

    mc_datapath_g2 #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_valid (ctrl_valid),
        .ctrl       (ctrl),
        .ctrl_ready (ctrl_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .opcode     (opcode),
        .outr       (outr),
        .psw        (psw)
`ifdef DP_DBG_EN
        ,
        .dbg_en     (dbg_en),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input ctrl_t c);
        ctrl       = c;
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
    endtask

    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c           = '0;
        c.mem_rd    = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_ONE;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_SRC_ALU;
        c.pc_write  = 1'b1;
        return c;
    endfunction

    task automatic fetch(input logic [15:0] instr);
        step(fetch_ctrl());
        mem_ack   = 1'b1;
        mem_rdata = instr;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Loads B with r[IR[10:8]], then passes it through the ALU into OUTR.
    task automatic peek_dst();
        ctrl_t c;
        c = '0; c.reg_dst = 1'b1;
        step(c);
        c = '0; c.alu_op = ALU_PASSB; c.alu_src_b = SRC_B_REG; c.outr_en = 1'b1;
        step(c);
    endtask

    task automatic peek_pc();
        ctrl_t c;
        c = '0; c.alu_src_a = SRC_A_PC; c.alu_src_b = SRC_B_ZERO; c.alu_op = ALU_ADD; c.outr_en = 1'b1;
        step(c);
    endtask

    task automatic alu_step(input alu_op_e op, input src_b_e sb);
        ctrl_t c;
        c = '0; c.alu_src_a = SRC_A_REG; c.alu_src_b = sb; c.alu_op = op; c.psw_en = 1'b1; c.outr_en = 1'b1;
        step(c);
    endtask

    task automatic llh_step(input logic lh_sel);
        ctrl_t c;
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = M2R_LLH; c.ll_or_lh = lh_sel;
        step(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (ctrl_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ctrl_ready); end
        checks++; if (opcode !== 16'h0000) begin failures++; $display("FAIL reset_opcode got=%h exp=0000", opcode); end
        checks++; if (outr !== 16'h0000) begin failures++; $display("FAIL reset_outr got=%h exp=0000", outr); end
        checks++; if (psw !== 4'b0000) begin failures++; $display("FAIL reset_psw got=%b exp=0000", psw); end
        peek_pc();
        checks++; if (outr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", outr); end
    endtask

    task automatic test_ll_lh();
        ctrl_t c;
        fetch(16'h017F);
        checks++; if (opcode !== 16'h017F) begin failures++; $display("FAIL ll_fetch_opcode got=%h exp=017f", opcode); end
        llh_step(1'b0);
        peek_dst();
        checks++; if (outr !== 16'h007F) begin failures++; $display("FAIL ll_r1 got=%h exp=007f", outr); end
        c = '0; c.reg_dst = 1'b1;
        step(c);
        llh_step(1'b1);
        peek_dst();
        checks++; if (outr !== 16'h7F7F) begin failures++; $display("FAIL lh_r1 got=%h exp=7f7f", outr); end
    endtask

    task automatic test_fetch_stall();
        ctrl       = fetch_ctrl();
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL stall_req[%0d] got=%b exp=1", i, mem_req); end
            checks++; if (mem_addr !== 8'h01) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=01", i, mem_addr); end
            checks++; if (ctrl_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, ctrl_ready); end
            checks++; if (opcode !== 16'h017F) begin failures++; $display("FAIL stall_ir_early[%0d] got=%h exp=017f", i, opcode); end
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h0205;
            end
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_req_drop got=%b exp=0", mem_req); end
        checks++; if (opcode !== 16'h0205) begin failures++; $display("FAIL stall_ir got=%h exp=0205", opcode); end
        checks++; if (ctrl_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_back got=%b exp=1", ctrl_ready); end
        peek_pc();
        checks++; if (outr !== 16'h0002) begin failures++; $display("FAIL stall_pc got=%h exp=0002", outr); end
    endtask

    task automatic test_ack_ignored();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        checks++; if (opcode !== 16'h0205) begin failures++; $display("FAIL idle_ack_ir got=%h exp=0205", opcode); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_sub_branch();
        ctrl_t c;
        llh_step(1'b0);
        fetch(16'h0240);
        c = '0; c.reg_dst = 1'b1;
        step(c);
        c = '0; c.reg_dst = 1'b1; c.alu_src_a = SRC_A_REG; c.alu_src_b = SRC_B_REG; c.alu_op = ALU_SUB; c.psw_en = 1'b1;
        step(c);
        checks++; if (psw !== 4'b0110) begin failures++; $display("FAIL sub_psw got=%b exp=0110", psw); end
        c = '0; c.branch = 1'b1; c.cond = COND_NZ; c.pc_src = PC_SRC_JUMP;
        step(c);
        peek_pc();
        checks++; if (outr !== 16'h0003) begin failures++; $display("FAIL bnz_not_taken got=%h exp=0003", outr); end
        c = '0; c.branch = 1'b1; c.cond = COND_Z; c.pc_src = PC_SRC_JUMP;
        step(c);
        peek_pc();
        checks++; if (outr !== 16'h0240) begin failures++; $display("FAIL bz_taken got=%h exp=0240", outr); end
    endtask

    task automatic test_add_flags();
        ctrl_t c;
        fetch(16'h03FF);
        llh_step(1'b0);
        fetch(16'h037F);
        c = '0; c.reg_dst = 1'b1;
        step(c);
        llh_step(1'b1);
        c = '0;
        step(c);
        alu_step(ALU_ADD, SRC_B_ONE);
        checks++; if (outr !== 16'h8000) begin failures++; $display("FAIL add_result got=%h exp=8000", outr); end
        checks++; if (psw !== 4'b1001) begin failures++; $display("FAIL add_psw got=%b exp=1001", psw); end
        alu_step(ALU_ADD, SRC_B_IMM);
        checks++; if (outr !== 16'h7FFE) begin failures++; $display("FAIL carry_result got=%h exp=7ffe", outr); end
        checks++; if (psw !== 4'b0010) begin failures++; $display("FAIL carry_psw got=%b exp=0010", psw); end
        alu_step(ALU_XOR, SRC_B_REG);
        checks++; if (outr !== 16'h7FFF) begin failures++; $display("FAIL xor_result got=%h exp=7fff", outr); end
        checks++; if (psw !== 4'b0000) begin failures++; $display("FAIL xor_psw got=%b exp=0000", psw); end
        alu_step(ALU_ADD, SRC_B_IMM);
        alu_step(ALU_ADC, SRC_B_ONE);
        checks++; if (outr !== 16'h8001) begin failures++; $display("FAIL adc_result got=%h exp=8001", outr); end
        checks++; if (psw !== 4'b1001) begin failures++; $display("FAIL adc_psw got=%b exp=1001", psw); end
        alu_step(ALU_SBC, SRC_B_ONE);
        checks++; if (outr !== 16'h7FFD) begin failures++; $display("FAIL sbc_result got=%h exp=7ffd", outr); end
        checks++; if (psw !== 4'b0010) begin failures++; $display("FAIL sbc_psw got=%b exp=0010", psw); end
    endtask

    task automatic test_store();
        ctrl_t c;
        fetch(16'h04EF);
        llh_step(1'b0);
        fetch(16'h04BE);
        c = '0; c.reg_dst = 1'b1;
        step(c);
        llh_step(1'b1);
        fetch(16'h0442);
        c = '0; c.reg_dst = 1'b1; c.alu_op = ALU_PASSB; c.alu_src_b = SRC_B_IMM; c.imm_long = 1'b1;
        step(c);
        c = '0; c.mem_wr = 1'b1; c.iord = 1'b1;
        ctrl       = c;
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL st_req[%0d] got=%b exp=1", i, mem_req); end
            checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL st_we[%0d] got=%b exp=1", i, mem_we); end
            checks++; if (mem_addr !== 8'h42) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=42", i, mem_addr); end
            checks++; if (mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL st_wdata[%0d] got=%h exp=beef", i, mem_wdata); end
            if (i == 1) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL st_req_drop got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL st_we_drop got=%b exp=0", mem_we); end
    endtask

    task automatic test_back_to_back();
        ctrl_t c1, c2;
        c1 = '0; c1.alu_src_a = SRC_A_REG; c1.alu_src_b = SRC_B_ONE; c1.alu_op = ALU_ADD; c1.outr_en = 1'b1;
        c2 = '0; c2.alu_src_a = SRC_A_REG; c2.alu_src_b = SRC_B_IMM; c2.alu_op = ALU_ADD; c2.outr_en = 1'b1;
        ctrl       = c1;
        ctrl_valid = 1'b1;
        tick();
        checks++; if (outr !== 16'h0006) begin failures++; $display("FAIL b2b_first got=%h exp=0006", outr); end
        checks++; if (ctrl_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ctrl_ready); end
        ctrl = c2;
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
        checks++; if (outr !== 16'h0007) begin failures++; $display("FAIL b2b_second got=%h exp=0007", outr); end
    endtask

`ifdef DP_DBG_EN
    task automatic test_debug();
        ctrl_t c;
        c = '0; c.alu_op = ALU_PASSB; c.alu_src_b = SRC_B_IMM; c.imm_long = 1'b1; c.outr_en = 1'b1;
        dbg_en     = 1'b1;
        dbg_we     = 1'b0;
        dbg_addr   = 8'h10;
        ctrl       = c;
        ctrl_valid = 1'b1;
        #1;
        checks++; if (ctrl_ready !== 1'b0) begin failures++; $display("FAIL dbg_prio_ready got=%b exp=0", ctrl_ready); end
        tick();
        dbg_en = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL dbg_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL dbg_addr got=%h exp=10", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL dbg_we got=%b exp=0", mem_we); end
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL dbg_ack got=%b exp=1", dbg_ack); end
        checks++; if (dbg_rdata !== 16'h1234) begin failures++; $display("FAIL dbg_rdata got=%h exp=1234", dbg_rdata); end
        checks++; if (outr !== 16'h0007) begin failures++; $display("FAIL dbg_step_held got=%h exp=0007", outr); end
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
        checks++; if (outr !== 16'h0042) begin failures++; $display("FAIL dbg_step_after got=%h exp=0042", outr); end
        checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse got=%b exp=0", dbg_ack); end
        checks++; if (dbg_rdata !== 16'h1234) begin failures++; $display("FAIL dbg_rdata_hold got=%h exp=1234", dbg_rdata); end
    endtask

    task automatic test_reset_mid_dbg();
        dbg_en   = 1'b1;
        dbg_addr = 8'h20;
        tick();
        dbg_en = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rdbg_req got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rdbg_req_drop got=%b exp=0", mem_req); end
        checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL rdbg_ack got=%b exp=0", dbg_ack); end
        rst_n = 1'b1;
        tick();
    endtask
`endif

    task automatic test_reset_mid_mem();
        ctrl       = fetch_ctrl();
        ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
        ctrl       = '0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmem_req got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmem_req_drop got=%b exp=0", mem_req); end
        checks++; if (opcode !== 16'h0000) begin failures++; $display("FAIL rmem_opcode got=%h exp=0000", opcode); end
        checks++; if (outr !== 16'h0000) begin failures++; $display("FAIL rmem_outr got=%h exp=0000", outr); end
        rst_n = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmem_req_after got=%b exp=0", mem_req); end
    endtask

    initial begin
        rst_n      = 1'b0;
        ctrl_valid = 1'b0;
        ctrl       = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
`ifdef DP_DBG_EN
        dbg_en     = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
`endif
        test_reset();
        test_ll_lh();
        test_fetch_stall();
        test_ack_ignored();
        test_sub_branch();
        test_add_flags();
        test_store();
        test_back_to_back();
`ifdef DP_DBG_EN
        test_debug();
`endif
        test_reset_mid_mem();
`ifdef DP_DBG_EN
        test_reset_mid_dbg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
